// File: rtl/hazard_pkg.sv
// Shared decode constants, tracker state type and decode helpers
// for the pipeline stall/flush controller.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return op == OP_LB || op == OP_LH ||
           op == OP_LW || op == OP_LBU ||
           op == OP_LHU;
  endfunction

  // Ops that read rt as a source register
  function automatic logic reads_rt(
    input logic [5:0] op
  );
    return op == OP_RTYPE || op == OP_BEQ ||
           op == OP_BNE || op == OP_SB ||
           op == OP_SH || op == OP_SW;
  endfunction

  function automatic logic reads_rs(
    input logic [5:0] op
  );
    return !(op == OP_J || op == OP_JAL);
  endfunction

  function automatic logic is_md(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return op == OP_RTYPE &&
           fn >= FN_MULT && fn <= FN_DIVU;
  endfunction

  function automatic logic is_hl(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return op == OP_RTYPE &&
           fn >= FN_MFHI && fn <= FN_MTLO;
  endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Occupancy tracker for the shared multi-cycle mul/div unit:
// IDLE/MD_BUSY state and a down-counter of remaining busy cycles.
module muldiv_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic Clock,
  input  logic Reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD =
    CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD =
    CNT_W'(DIV_CYCLES - 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
          end
        end
        MD_BUSY: begin
          // Counter reaching zero ends the busy window
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/stall_flush_controller.sv
// Load-use and mul/div hazard control for the five-stage pipeline.
// Optional STALL_COUNT_EN adds a saturating stall-cycle counter.
module stall_flush_controller
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ID_Instruction,
  input  logic [31:0] EX_Instruction,
  input  logic        Branch_Taken,
  output logic        PC_WriteEnable,
  output logic        IFID_WriteEnable,
  output logic        WriteEnableMuxControl,
  output logic        IFID_Flush,
  output logic        MulDiv_Start,
  output logic [1:0]  MulDiv_Op,
  output logic        MulDiv_Busy
`ifdef STALL_COUNT_EN
  ,
  output logic [31:0] Stall_Count
`endif
);

  logic [5:0] id_op, id_fn, ex_op;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       rs_hit, rt_hit;
  logic       load_use, md_hazard, stall;
  logic       id_md, id_hl;

  assign id_op = ID_Instruction[31:26];
  assign id_rs = ID_Instruction[25:21];
  assign id_rt = ID_Instruction[20:16];
  assign id_fn = ID_Instruction[5:0];
  assign ex_op = EX_Instruction[31:26];
  assign ex_rt = EX_Instruction[20:16];

  assign rs_hit = ex_rt == id_rs && reads_rs(id_op);
  assign rt_hit = ex_rt == id_rt && reads_rt(id_op);

  assign load_use = is_load(ex_op) && ex_rt != 5'd0 &&
                    (rs_hit || rt_hit);

  assign id_md = is_md(id_op, id_fn);
  assign id_hl = is_hl(id_op, id_fn);

  assign md_hazard = MulDiv_Busy && (id_md || id_hl);
  assign stall     = load_use || md_hazard;

  assign PC_WriteEnable        = !stall;
  assign IFID_WriteEnable      = !stall;
  assign WriteEnableMuxControl = !stall;
  // A stalled branch re-resolves next cycle, so no flush now
  assign IFID_Flush            = !stall && Branch_Taken;

  assign MulDiv_Start = id_md && !MulDiv_Busy && !load_use;
  assign MulDiv_Op    = id_fn[1:0];

  muldiv_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tracker (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (MulDiv_Start),
    .is_div (id_fn[1]),
    .busy   (MulDiv_Busy)
  );

`ifdef STALL_COUNT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      Stall_Count <= '0;
    else if (stall && Stall_Count != 32'hFFFF_FFFF)
      Stall_Count <= Stall_Count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stall_flush_controller.sv
// Scoreboard bench: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_stall_flush_controller;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] ID_Instruction = '0;
  logic [31:0] EX_Instruction = '0;
  logic        Branch_Taken = 1'b0;
  logic        PC_WriteEnable;
  logic        IFID_WriteEnable;
  logic        WriteEnableMuxControl;
  logic        IFID_Flush;
  logic        MulDiv_Start;
  logic [1:0]  MulDiv_Op;
  logic        MulDiv_Busy;
`ifdef STALL_COUNT_EN
  logic [31:0] Stall_Count;
`endif

  stall_flush_controller #(
    .MULT_CYCLES (4),
    .DIV_CYCLES  (32),
    .CNT_W       (6)
  ) dut (
    .Clock                 (Clock),
    .Reset                 (Reset),
    .ID_Instruction        (ID_Instruction),
    .EX_Instruction        (EX_Instruction),
    .Branch_Taken          (Branch_Taken),
    .PC_WriteEnable        (PC_WriteEnable),
    .IFID_WriteEnable      (IFID_WriteEnable),
    .WriteEnableMuxControl (WriteEnableMuxControl),
    .IFID_Flush            (IFID_Flush),
    .MulDiv_Start          (MulDiv_Start),
    .MulDiv_Op             (MulDiv_Op),
    .MulDiv_Busy           (MulDiv_Busy)
`ifdef STALL_COUNT_EN
    ,
    .Stall_Count           (Stall_Count)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] rt_i(
    input int rs, input int rt,
    input int rd, input int fn
  );
    return {6'd0, 5'(rs), 5'(rt), 5'(rd),
            5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] i_i(
    input int op, input int rs, input int rt
  );
    return {6'(op), 5'(rs), 5'(rt), 16'd0};
  endfunction

  // {pc, ifid, mux, flush, start, op[1:0], busy}
  function automatic logic [7:0] ev(
    input logic st, input logic fl,
    input logic sr, input logic [1:0] op,
    input logic bz
  );
    return {!st, !st, !st, fl, sr, op, bz};
  endfunction

  task automatic step(
    input logic        rs,
    input logic [31:0] id,
    input logic [31:0] ex,
    input logic        br,
    input logic [7:0]  v,
    input string       nm
  );
    exp_t e;
    @(posedge Clock);
    #1;
    Reset          = rs;
    ID_Instruction = id;
    EX_Instruction = ex;
    Branch_Taken   = br;
    e.name = nm;
    e.v    = v;
    q.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e = q.pop_front();
      got = {PC_WriteEnable, IFID_WriteEnable,
             WriteEnableMuxControl, IFID_Flush,
             MulDiv_Start, MulDiv_Op, MulDiv_Busy};
      n_tests++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s got=%b exp=%b",
                 e.name, got, e.v);
      end
    end
  end

  localparam logic [31:0] NOP = 32'd0;

  logic [31:0] add_t0, add_z, lw_t0, lw_z, sw_t0;
  logic [31:0] j_rs8, addi_t0, beq_t0;
  logic [31:0] mult_i, mult_t0, mflo_i, mfhi_i, div_i;

  initial begin
    add_t0  = rt_i(8, 10, 9, 'h20);
    add_z   = rt_i(0, 0, 9, 'h20);
    lw_t0   = i_i('h23, 16, 8);
    lw_z    = i_i('h23, 16, 0);
    sw_t0   = i_i('h2B, 16, 8);
    j_rs8   = {6'h02, 26'h100_0000};
    addi_t0 = i_i('h08, 16, 8);
    beq_t0  = i_i('h04, 8, 9);
    mult_i  = rt_i(4, 5, 0, 'h18);
    mult_t0 = rt_i(8, 5, 0, 'h18);
    mflo_i  = rt_i(0, 0, 8, 'h12);
    mfhi_i  = rt_i(0, 0, 8, 'h10);
    div_i   = rt_i(4, 5, 0, 'h1A);

    step(0, NOP, NOP, 0,
         ev(0, 0, 0, 2'b00, 0), "reset");
    step(1, add_t0, lw_t0, 0,
         ev(1, 0, 0, 2'b00, 0), "lu_rs_stall");
    step(1, add_t0, NOP, 0,
         ev(0, 0, 0, 2'b00, 0), "lu_after");
    step(1, add_z, lw_z, 0,
         ev(0, 0, 0, 2'b00, 0), "lu_zero");
    step(1, sw_t0, lw_t0, 0,
         ev(1, 0, 0, 2'b00, 0), "lu_sw_rt");
    step(1, j_rs8, lw_t0, 1,
         ev(0, 1, 0, 2'b00, 0), "j_no_stall");
    step(1, addi_t0, lw_t0, 0,
         ev(0, 0, 0, 2'b00, 0), "addi_rt");
    step(1, beq_t0, lw_t0, 1,
         ev(1, 0, 0, 2'b00, 0), "br_stall");
    step(1, beq_t0, NOP, 1,
         ev(0, 1, 0, 2'b00, 0), "br_flush");

    step(1, mult_i, NOP, 0,
         ev(0, 0, 1, 2'b00, 0), "mult_start");
    for (int i = 0; i < 4; i++)
      step(1, mflo_i, NOP, 0,
           ev(1, 0, 0, 2'b10, 1), "mflo_stall");
    step(1, mflo_i, NOP, 0,
         ev(0, 0, 0, 2'b10, 0), "mflo_go");

    step(1, mult_t0, lw_t0, 0,
         ev(1, 0, 0, 2'b00, 0), "lu_md_hold");
    step(1, mult_t0, NOP, 0,
         ev(0, 0, 1, 2'b00, 0), "lu_md_start");
    for (int i = 0; i < 4; i++)
      step(1, NOP, NOP, 0,
           ev(0, 0, 0, 2'b00, 1), "mult_busy");
    step(1, NOP, NOP, 0,
         ev(0, 0, 0, 2'b00, 0), "mult_done");

    step(1, div_i, NOP, 0,
         ev(0, 0, 1, 2'b10, 0), "div1_start");
    for (int i = 0; i < 32; i++)
      step(1, div_i, NOP, 0,
           ev(1, 0, 0, 2'b10, 1), "div2_stall");
    step(1, div_i, NOP, 0,
         ev(0, 0, 1, 2'b10, 0), "div2_start");
    for (int i = 0; i < 21; i++)
      step(1, NOP, NOP, 0,
           ev(0, 0, 0, 2'b00, 1), "div2_busy");
    step(0, mfhi_i, NOP, 0,
         ev(0, 0, 0, 2'b00, 0), "rst_mid_busy");
    step(1, mfhi_i, NOP, 0,
         ev(0, 0, 0, 2'b00, 0), "hl_after_rst");
    step(1, NOP, NOP, 0,
         ev(0, 0, 0, 2'b00, 0), "idle_after");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge Clock);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
